// File: rtl/store_split_unit_pkg.sv
// Shared types for the store split unit: store op encoding, FSM states and op legality.
package store_split_unit_pkg;

    localparam int STORE_OP_WIDTH = 2;

    typedef enum logic [STORE_OP_WIDTH-1:0] {
        STORE_OP_SB = 2'd0,
        STORE_OP_SH = 2'd1,
        STORE_OP_SW = 2'd2,
        STORE_OP_SD = 2'd3
    } store_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_RESP,
        ST_FAULT
    } state_e;

    // A doubleword store only exists on a 64-bit datapath.
    function automatic logic op_legal(input store_op_e op, input int xlen);
        return !(op == STORE_OP_SD && xlen == 32);
    endfunction

endpackage

// File: rtl/store_split_unit_if.sv
// Store request, bus beat and completion signals of the store split unit.
interface store_split_unit_if #(parameter int XLEN = 32);
    import store_split_unit_pkg::*;

    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    store_op_e       req_op;
    logic [XLEN-1:0] req_data;

    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [NB-1:0]   mem_wmask;

    logic            resp_valid;
    logic            resp_fault;

    modport slave (
        input  req_valid, req_addr, req_op, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, resp_valid, resp_fault
    );

    modport master (
        output req_valid, req_addr, req_op, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, resp_valid, resp_fault
    );

endinterface

// File: rtl/store_split_unit_lane_shifter.sv
// Combinational lane placement: shifts size-masked store data and its byte mask across
// two bus words and flags stores that cross a word or are misaligned for their size.
module store_lane_shifter
    import store_split_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  store_op_e                 op,
    input  logic [XLEN-1:0]           data,
    output logic [2*XLEN-1:0]         wide,
    output logic [2*XLEN/8-1:0]       wmask2,
    output logic                      split,
    output logic                      misaligned
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int W2   = 2 * NB;

    logic [3:0]      size;
    logic [W2-1:0]   bmask;
    logic [XLEN-1:0] data_m;

    // NOTE: every output of a combinational block gets a value on every path; a
    // missing default here would infer a latch.
    always_comb begin
        size       = 4'(1) << op;
        bmask      = (W2'(1) << size) - W2'(1);
        misaligned = (off & OFFW'(size - 4'd1)) != '0;
        data_m     = '0;
        // Lanes beyond the store size are zeroed so unused bus lanes read as 0.
        for (int i = 0; i < NB; i++) begin
            data_m[8*i +: 8] = bmask[i] ? data[8*i +: 8] : 8'h00;
        end
        wide   = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
        wmask2 = bmask << off;
        split  = |wmask2[W2-1:NB];
    end

endmodule

// File: rtl/store_split_unit.sv
// Store path FSM: accepts one store, issues one or two lane-placed bus beats (or a fault
// response), then pulses a completion response.
module store_split_unit
    import store_split_unit_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic               clk,
    input logic               rst,
    store_split_unit_if.slave bus
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    state_e            state_q, state_d;
    logic [2*XLEN-1:0] wide_q, wide_d;
    logic [2*NB-1:0]   wmask2_q, wmask2_d;
    logic [31:0]       base_q, base_d;
    logic              split_q, split_d;

    logic [2*XLEN-1:0] sh_wide;
    logic [2*NB-1:0]   sh_wmask2;
    logic              sh_split;
    logic              sh_misaligned;

    logic              req_ready;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NB-1:0]     mem_wmask;
    logic              resp_valid;
    logic              resp_fault;

    store_lane_shifter #(.XLEN(XLEN)) u_shifter (
        .off        (bus.req_addr[OFFW-1:0]),
        .op         (bus.req_op),
        .data       (bus.req_data),
        .wide       (sh_wide),
        .wmask2     (sh_wmask2),
        .split      (sh_split),
        .misaligned (sh_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        wide_d     = wide_q;
        wmask2_d   = wmask2_q;
        base_d     = base_q;
        split_d    = split_q;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    wide_d   = sh_wide;
                    wmask2_d = sh_wmask2;
                    split_d  = sh_split;
                    base_d   = {bus.req_addr[31:OFFW], {OFFW{1'b0}}};
                    if (!op_legal(bus.req_op, XLEN) || (sh_misaligned && !ALLOW_MISALIGNED)) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = base_q;
                mem_wdata = wide_q[XLEN-1:0];
                mem_wmask = wmask2_q[NB-1:0];
                if (bus.mem_ready) state_d = split_q ? ST_BEAT1 : ST_RESP;
            end
            ST_BEAT1: begin
                // The second beat wraps to address 0 past the top of the address space.
                mem_valid = 1'b1;
                mem_addr  = base_q + 32'(NB);
                mem_wdata = wide_q[2*XLEN-1:XLEN];
                mem_wmask = wmask2_q[2*NB-1:NB];
                if (bus.mem_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FAULT: begin
                resp_valid = 1'b1;
                resp_fault = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same
    // pre-edge values; the beat fields are reset too so the bus outputs are defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wide_q   <= '0;
            wmask2_q <= '0;
            base_q   <= '0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wide_q   <= wide_d;
            wmask2_q <= wmask2_d;
            base_q   <= base_d;
            split_q  <= split_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.mem_valid  = mem_valid;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_wmask  = mem_wmask;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_fault = resp_fault;

endmodule

// File: tb/tb_store_split_unit.sv
// Directed bench for store_split_unit: 32-bit with and without misaligned support, and 64-bit.
module tb_store_split_unit;
    import store_split_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    store_split_unit_if #(.XLEN(32)) bus_a ();
    store_split_unit_if #(.XLEN(32)) bus_b ();
    store_split_unit_if #(.XLEN(64)) bus_c ();

    store_split_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    store_split_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    store_split_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Each req task presents one request for a single cycle; it returns at the
    // negedge of the cycle following acceptance.
    task automatic req_a(input logic [31:0] addr, input store_op_e op, input logic [31:0] data);
        bus_a.req_valid = 1'b1; bus_a.req_addr = addr; bus_a.req_op = op; bus_a.req_data = data;
        #1 check("a_accept_ready", 64'(bus_a.req_ready), 64'(1));
        step();
        bus_a.req_valid = 1'b0;
    endtask

    task automatic req_b(input logic [31:0] addr, input store_op_e op, input logic [31:0] data);
        bus_b.req_valid = 1'b1; bus_b.req_addr = addr; bus_b.req_op = op; bus_b.req_data = data;
        #1 check("b_accept_ready", 64'(bus_b.req_ready), 64'(1));
        step();
        bus_b.req_valid = 1'b0;
    endtask

    task automatic req_c(input logic [31:0] addr, input store_op_e op, input logic [63:0] data);
        bus_c.req_valid = 1'b1; bus_c.req_addr = addr; bus_c.req_op = op; bus_c.req_data = data;
        #1 check("c_accept_ready", 64'(bus_c.req_ready), 64'(1));
        step();
        bus_c.req_valid = 1'b0;
    endtask

    task automatic beat_a(input string tag, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata);
        check({tag, "_valid"}, 64'(bus_a.mem_valid), 64'(1));
        check({tag, "_addr"},  64'(bus_a.mem_addr),  64'(addr));
        check({tag, "_mask"},  64'(bus_a.mem_wmask), 64'(mask));
        check({tag, "_wdata"}, 64'(bus_a.mem_wdata), 64'(wdata));
        check({tag, "_resp"},  64'(bus_a.resp_valid), 64'(0));
    endtask

    task automatic resp_a(input string tag);
        check({tag, "_resp_valid"}, 64'(bus_a.resp_valid), 64'(1));
        check({tag, "_resp_fault"}, 64'(bus_a.resp_fault), 64'(0));
        check({tag, "_no_beat"},    64'(bus_a.mem_valid),  64'(0));
        step();
        check({tag, "_idle_ready"}, 64'(bus_a.req_ready),  64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_op = STORE_OP_SB; bus_a.req_data = '0;
        bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_op = STORE_OP_SB; bus_b.req_data = '0;
        bus_c.req_valid = 1'b0; bus_c.req_addr = '0; bus_c.req_op = STORE_OP_SB; bus_c.req_data = '0;
        bus_a.mem_ready = 1'b1; bus_b.mem_ready = 1'b1; bus_c.mem_ready = 1'b1;

        // Reset state
        #1;
        check("rst_req_ready",  64'(bus_a.req_ready),  64'(1));
        check("rst_mem_valid",  64'(bus_a.mem_valid),  64'(0));
        check("rst_mem_addr",   64'(bus_a.mem_addr),   64'(0));
        check("rst_mem_wdata",  64'(bus_a.mem_wdata),  64'(0));
        check("rst_mem_wmask",  64'(bus_a.mem_wmask),  64'(0));
        check("rst_resp_valid", 64'(bus_a.resp_valid), 64'(0));
        check("rst_resp_fault", 64'(bus_a.resp_fault), 64'(0));
        step(); step();
        rst = 1'b0;
        step();

        // 1: aligned SW, single beat, resp at T+2
        req_a(32'h0000_0100, STORE_OP_SW, 32'hDEAD_BEEF);
        beat_a("sw_aligned", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        check("sw_busy_ready", 64'(bus_a.req_ready), 64'(0));
        step();
        resp_a("sw_aligned");

        // 2: SB into top lane; upper data bits must not leak onto the bus
        req_a(32'h0000_0103, STORE_OP_SB, 32'h1234_56A5);
        beat_a("sb_lane3", 32'h0000_0100, 4'b1000, 32'hA500_0000);
        step();
        resp_a("sb_lane3");

        // 3: misaligned SW crossing a word, two beats, resp at T+3
        req_a(32'h0000_0102, STORE_OP_SW, 32'h1122_3344);
        beat_a("sw_split_b0", 32'h0000_0100, 4'b1100, 32'h3344_0000);
        step();
        beat_a("sw_split_b1", 32'h0000_0104, 4'b0011, 32'h0000_1122);
        step();
        resp_a("sw_split");

        // 4: SH at the top of the address space, second beat wraps to 0
        req_a(32'hFFFF_FFFF, STORE_OP_SH, 32'h0000_BEEF);
        beat_a("sh_wrap_b0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        step();
        beat_a("sh_wrap_b1", 32'h0000_0000, 4'b0001, 32'h0000_00BE);
        step();
        resp_a("sh_wrap");

        // 6: back-pressure in BEAT0 keeps the beat stable, then reset during BEAT1
        bus_a.mem_ready = 1'b0;
        req_a(32'h0000_0102, STORE_OP_SW, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            beat_a("stall_b0", 32'h0000_0100, 4'b1100, 32'hF00D_0000);
            step();
        end
        beat_a("stall_b0_last", 32'h0000_0100, 4'b1100, 32'hF00D_0000);
        bus_a.mem_ready = 1'b1;
        step();
        bus_a.mem_ready = 1'b0;
        beat_a("stall_b1", 32'h0000_0104, 4'b0011, 32'h0000_CAFE);
        rst = 1'b1;
        #1;
        check("mid_rst_mem_valid", 64'(bus_a.mem_valid), 64'(0));
        check("mid_rst_mem_addr",  64'(bus_a.mem_addr),  64'(0));
        step();
        rst = 1'b0;
        bus_a.mem_ready = 1'b1;
        step();
        check("post_rst_ready", 64'(bus_a.req_ready),  64'(1));
        check("post_rst_resp",  64'(bus_a.resp_valid), 64'(0));

        // 5: ALLOW=0 misaligned SW faults at T+1 with no bus access
        req_b(32'h0000_0101, STORE_OP_SW, 32'h5566_7788);
        check("na_fault_valid", 64'(bus_b.resp_valid), 64'(1));
        check("na_fault_flag",  64'(bus_b.resp_fault), 64'(1));
        check("na_fault_nobus", 64'(bus_b.mem_valid),  64'(0));
        step();
        check("na_fault_done",  64'(bus_b.resp_valid), 64'(0));
        check("na_fault_ready", 64'(bus_b.req_ready),  64'(1));

        // 5b: SD is illegal on a 32-bit datapath even when aligned
        req_b(32'h0000_0100, STORE_OP_SD, 32'h0102_0304);
        check("sd32_fault_valid", 64'(bus_b.resp_valid), 64'(1));
        check("sd32_fault_flag",  64'(bus_b.resp_fault), 64'(1));
        check("sd32_fault_nobus", 64'(bus_b.mem_valid),  64'(0));
        step();

        // Aligned SW with ALLOW=0 completes normally
        req_b(32'h0000_0200, STORE_OP_SW, 32'hA1B2_C3D4);
        check("na_sw_valid", 64'(bus_b.mem_valid), 64'(1));
        check("na_sw_addr",  64'(bus_b.mem_addr),  64'(32'h0000_0200));
        check("na_sw_mask",  64'(bus_b.mem_wmask), 64'(4'b1111));
        check("na_sw_wdata", 64'(bus_b.mem_wdata), 64'(32'hA1B2_C3D4));
        step();
        check("na_sw_resp",  64'(bus_b.resp_valid), 64'(1));
        check("na_sw_fault", 64'(bus_b.resp_fault), 64'(0));
        step();

        // XLEN=64: SD at offset 4 splits into masks F0 / 0F
        req_c(32'h0000_1004, STORE_OP_SD, 64'h0123_4567_89AB_CDEF);
        check("sd64_b0_valid", 64'(bus_c.mem_valid), 64'(1));
        check("sd64_b0_addr",  64'(bus_c.mem_addr),  64'(32'h0000_1000));
        check("sd64_b0_mask",  64'(bus_c.mem_wmask), 64'(8'hF0));
        check("sd64_b0_wdata", bus_c.mem_wdata,      64'h89AB_CDEF_0000_0000);
        step();
        check("sd64_b1_addr",  64'(bus_c.mem_addr),  64'(32'h0000_1008));
        check("sd64_b1_mask",  64'(bus_c.mem_wmask), 64'(8'h0F));
        check("sd64_b1_wdata", bus_c.mem_wdata,      64'h0000_0000_0123_4567);
        step();
        check("sd64_resp",     64'(bus_c.resp_valid), 64'(1));
        step();

        // XLEN=64: SW at offset 4 is aligned, one beat, upper data bytes dropped
        req_c(32'h0000_1004, STORE_OP_SW, 64'h0123_4567_89AB_CDEF);
        check("sw64_mask",  64'(bus_c.mem_wmask), 64'(8'hF0));
        check("sw64_wdata", bus_c.mem_wdata,      64'h89AB_CDEF_0000_0000);
        step();
        check("sw64_resp",   64'(bus_c.resp_valid), 64'(1));
        check("sw64_nobeat", 64'(bus_c.mem_valid),  64'(0));
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
